// File: rtl/alarm_minigame_ctrl.sv
// Service-4 alarm: rings on an MM:SS match, then requires ROUNDS correct switch-matching rounds.
// Optional build macro ALARM_GAME_TIMEOUT_EN adds a per-round tick timeout that falls back to ringing.
module alarm_minigame_ctrl #(
    parameter int         ROUNDS       = 3,
    parameter int         RING_TIMEOUT = 60,
    parameter int         GAME_TIMEOUT = 20,
    parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        spdt4,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        push_m,
    input  logic [9:0]  mini_game,
    output logic [9:0]  mini_game_led,
    output logic        alarm_on,
    output logic [2:0]  alarm_state,
    output logic [15:0] num,
    output logic        finish4
);

    // One shared tick counter serves both the ring and the per-round timeouts.
    localparam int CNT_MAX = (RING_TIMEOUT > GAME_TIMEOUT) ? RING_TIMEOUT : GAME_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [3:0] ROUNDS_NIB = 4'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RINGING = 3'd2,
        GAME    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        state;
    logic          push_m_q;
    logic [15:0]   prev_time;
    logic [9:0]    lfsr;
    logic [9:0]    target;
    logic [3:0]    rounds_done;
    logic [CW-1:0] tick_cnt;
    logic          ring_blink;

    logic          pm_rise;
    logic          match_edge;
    logic [9:0]    lfsr_next;
    logic [CW-1:0] tick_cnt_inc;
    logic [3:0]    rounds_inc;

    assign pm_rise      = push_m & ~push_m_q;
    assign match_edge   = (current_time == alarm_time) && (prev_time != alarm_time);
    assign lfsr_next    = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    assign tick_cnt_inc = tick_cnt + 1'b1;
    assign rounds_inc   = rounds_done + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            push_m_q      <= 1'b0;
            prev_time     <= 16'h0;
            lfsr          <= LFSR_SEED;
            target        <= 10'h0;
            rounds_done   <= 4'd0;
            tick_cnt      <= '0;
            ring_blink    <= 1'b0;
            mini_game_led <= 10'h0;
            alarm_on      <= 1'b0;
            alarm_state   <= 3'b000;
            num           <= 16'h0;
            finish4       <= 1'b0;
        end else begin
            push_m_q  <= push_m;
            prev_time <= current_time;
            lfsr      <= lfsr_next;

            // Outputs follow the state register by one cycle.
            mini_game_led <= 10'h0;
            alarm_on      <= 1'b0;
            alarm_state   <= 3'b000;
            num           <= 16'h0;
            finish4       <= 1'b0;
            case (state)
                RINGING: begin
                    alarm_state   <= 3'b001;
                    alarm_on      <= ring_blink;
                    mini_game_led <= 10'h3FF;
                end
                GAME: begin
                    alarm_state   <= 3'b010;
                    alarm_on      <= 1'b1;
                    mini_game_led <= target;
                    num           <= {4'h0, rounds_done, 4'h0, ROUNDS_NIB};
                end
                DONE: begin
                    alarm_state <= 3'b100;
                    finish4     <= 1'b1;
                    num         <= {4'h0, rounds_done, 4'h0, ROUNDS_NIB};
                end
                default: ;
            endcase

            if (!spdt4) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= ARMED;
                        tick_cnt    <= '0;
                        rounds_done <= 4'd0;
                    end
                    ARMED: begin
                        // prev_time keeps tracking in IDLE, so arming on an equal time never rings.
                        if (match_edge) begin
                            state      <= RINGING;
                            tick_cnt   <= '0;
                            ring_blink <= 1'b0;
                        end
                    end
                    RINGING: begin
                        if (pm_rise) begin
                            state       <= GAME;
                            target      <= lfsr;
                            rounds_done <= 4'd0;
                            tick_cnt    <= '0;
                        end else if (tick) begin
                            ring_blink <= ~ring_blink;
                            if (tick_cnt_inc == CW'(RING_TIMEOUT)) begin
                                state    <= ARMED;
                                tick_cnt <= '0;
                            end else begin
                                tick_cnt <= tick_cnt_inc;
                            end
                        end
                    end
                    GAME: begin
                        if (pm_rise) begin
                            tick_cnt <= '0;
                            if (mini_game == target) begin
                                rounds_done <= rounds_inc;
                                if (rounds_inc == ROUNDS_NIB) begin
                                    state <= DONE;
                                end else begin
                                    target <= lfsr;
                                end
                            end else begin
                                rounds_done <= 4'd0;
                                target      <= lfsr;
                            end
                        end
`ifdef ALARM_GAME_TIMEOUT_EN
                        else if (tick) begin
                            if (tick_cnt_inc == CW'(GAME_TIMEOUT)) begin
                                state       <= RINGING;
                                rounds_done <= 4'd0;
                                tick_cnt    <= '0;
                                ring_blink  <= 1'b0;
                            end else begin
                                tick_cnt <= tick_cnt_inc;
                            end
                        end
`else
                        else begin
                            tick_cnt <= tick_cnt;
                        end
`endif
                    end
                    DONE: state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_minigame_ctrl.sv
// Directed bench for alarm_minigame_ctrl: ring, timeout, mini game rounds, aborts and reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alarm_minigame_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        spdt4;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic        push_m;
    logic [9:0]  mini_game;
    logic [9:0]  mini_game_led;
    logic        alarm_on;
    logic [2:0]  alarm_state;
    logic [15:0] num;
    logic        finish4;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [9:0]  m;
    logic [9:0]  cur_t;

    alarm_minigame_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .spdt4        (spdt4),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .push_m       (push_m),
        .mini_game    (mini_game),
        .mini_game_led(mini_game_led),
        .alarm_on     (alarm_on),
        .alarm_state  (alarm_state),
        .num          (num),
        .finish4      (finish4)
    );

    always #5 clk = ~clk;

    // Reference x^10+x^7+1 sequence, used to predict each new target pattern.
    always @(posedge clk) begin
        if (reset) m <= 10'h2A5;
        else       m <= {m[8:0], m[9] ^ m[6]};
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    // One-cycle press; the new target is the LFSR value at the sampling edge.
    task automatic press();
        push_m = 1'b1;
        cur_t  = m;
        cyc(1);
        push_m = 1'b0;
        cyc(1);
    endtask

    task automatic ring_again();
        current_time = 16'h0731;
        cyc(1);
        current_time = 16'h0730;
        cyc(2);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tick = 1'b0; spdt4 = 1'b0; push_m = 1'b0;
        current_time = 16'h0; alarm_time = 16'h0; mini_game = 10'h0; cur_t = 10'h0;
        cyc(2);
        check("rst_state", 16'(alarm_state), 16'h0);
        check("rst_led", 16'(mini_game_led), 16'h0);
        check("rst_num", num, 16'h0);
        check("rst_on", 16'(alarm_on), 16'h0);
        check("rst_fin", 16'(finish4), 16'h0);
        reset = 1'b0;

        alarm_time = 16'h0730; current_time = 16'h0729; spdt4 = 1'b1;
        cyc(2);
        current_time = 16'h0730;
        cyc(1);
        check("ring_latency", 16'(alarm_state), 16'h0);
        cyc(1);
        check("ring_state", 16'(alarm_state), 16'h1);
        check("ring_led", 16'(mini_game_led), 16'h3FF);
        check("ring_on_entry", 16'(alarm_on), 16'h0);
        do_tick();
        check("ring_toggle1", 16'(alarm_on), 16'h1);
        do_tick();
        check("ring_toggle2", 16'(alarm_on), 16'h0);

        for (int i = 0; i < 57; i++) do_tick();
        check("ring_59_ticks", 16'(alarm_state), 16'h1);
        do_tick();
        check("ring_timeout_state", 16'(alarm_state), 16'h0);
        check("ring_timeout_on", 16'(alarm_on), 16'h0);

        spdt4 = 1'b0;
        cyc(1);
        spdt4 = 1'b1;
        cyc(4);
        check("arm_equal_no_ring", 16'(alarm_state), 16'h0);
        ring_again();
        check("rematch_ring", 16'(alarm_state), 16'h1);

        press();
        check("game_state", 16'(alarm_state), 16'h2);
        check("game_on", 16'(alarm_on), 16'h1);
        check("game_num0", num, 16'h0003);
        check("game_led0", 16'(mini_game_led), 16'(cur_t));
        mini_game = cur_t; press();
        check("round1_num", num, 16'h0103);
        check("round1_led", 16'(mini_game_led), 16'(cur_t));
        mini_game = cur_t; press();
        check("round2_num", num, 16'h0203);
        mini_game = ~cur_t; press();
        check("wrong_num", num, 16'h0003);
        check("wrong_led", 16'(mini_game_led), 16'(cur_t));
        check("wrong_led_nonzero", 16'(mini_game_led == 10'h0), 16'h0);
        mini_game = cur_t; press();
        check("again1_num", num, 16'h0103);

        mini_game = cur_t;
        push_m = 1'b1;
        cur_t = m;
        cyc(100);
        push_m = 1'b0;
        cyc(1);
        check("hold_one_round", num, 16'h0203);
        check("hold_led", 16'(mini_game_led), 16'(cur_t));

        mini_game = cur_t; press();
        check("done_state", 16'(alarm_state), 16'h4);
        check("done_fin", 16'(finish4), 16'h1);
        check("done_on", 16'(alarm_on), 16'h0);
        check("done_led", 16'(mini_game_led), 16'h0);
        check("done_num", num, 16'h0303);
        cyc(3);
        check("done_stays", 16'(alarm_state), 16'h4);
        spdt4 = 1'b0;
        cyc(2);
        check("idle_state", 16'(alarm_state), 16'h0);
        check("idle_fin", 16'(finish4), 16'h0);
        check("idle_num", num, 16'h0);

        spdt4 = 1'b1;
        cyc(1);
        ring_again();
        tick = 1'b1; push_m = 1'b1; cur_t = m;
        cyc(1);
        tick = 1'b0; push_m = 1'b0;
        cyc(1);
        check("press_beats_tick", 16'(alarm_state), 16'h2);
        check("press_tick_led", 16'(mini_game_led), 16'(cur_t));
`ifdef ALARM_GAME_TIMEOUT_EN
        for (int i = 0; i < 19; i++) do_tick();
        check("game_19_ticks", 16'(alarm_state), 16'h2);
        do_tick();
        check("game_timeout", 16'(alarm_state), 16'h1);
        press();
        check("game_reenter", 16'(alarm_state), 16'h2);
`endif
        spdt4 = 1'b0;
        cyc(2);
        check("abort_game", 16'(alarm_state), 16'h0);
        check("abort_on", 16'(alarm_on), 16'h0);

        spdt4 = 1'b1;
        cyc(1);
        ring_again();
        check("ring_before_reset", 16'(alarm_state), 16'h1);
        reset = 1'b1;
        cyc(1);
        check("reset_state", 16'(alarm_state), 16'h0);
        check("reset_led", 16'(mini_game_led), 16'h0);
        reset = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
